// File: rtl/bcd2bin_seq_ctrl.sv
// Multi-cycle BCD-to-binary converter: one reverse double-dabble step per clock,
// with valid/ready handshakes on the input and output sides.
module bcd2bin_seq_ctrl #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int OUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      binary_out,
    output logic                  bad_digit,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    shifter_q, shifter_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   binary_q, binary_d;
    logic               bad_q, bad_d;

    logic [SH_W-1:0]    step_val;
    logic               in_bad;

    // One reverse double-dabble step: halve, then pull each BCD nibble back into range.
    always_comb begin
        step_val = shifter_q >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (step_val[BIN_W + 4*d +: 4] >= 4'd8) begin
                step_val[BIN_W + 4*d +: 4] = step_val[BIN_W + 4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        in_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        binary_d    = binary_q;
        bad_d       = bad_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shifter_d = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d     = '0;
                    err_d     = in_bad;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shifter_d = step_val;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    binary_d = '0;
                    if (!err_q) begin
                        binary_d[BIN_W-1:0] = step_val[BIN_W-1:0];
                    end
                    bad_d       = err_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: every register, including the datapath, is reset so an aborted conversion leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shifter_q   <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            binary_q    <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            binary_q    <= binary_d;
            bad_q       <= bad_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SHIFT) || (state_q == DONE);
    assign out_valid  = out_valid_q;
    assign binary_out = binary_q;
    assign bad_digit  = bad_q;

endmodule

// File: tb/tb_bcd2bin_seq_ctrl.sv
// Directed bench for bcd2bin_seq_ctrl: decimal reference model feeding a result
// scoreboard, latency/handshake checks, backpressure, mid-conversion reset, sweep.
module tb_bcd2bin_seq_ctrl;

    typedef struct packed {
        logic [15:0] bin;
        logic        bad;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] binary_out;
    logic        bad_digit;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    bcd2bin_seq_ctrl #(.DIGITS(4), .BIN_W(14), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bcd_in     (bcd_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .bad_digit  (bad_digit),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal interpretation of the digits, independent of the shift/subtract algorithm.
    function automatic exp_t ref_model(input logic [15:0] bcd);
        exp_t r;
        int   val;
        logic [3:0] dg;
        r.bad = 1'b0;
        val = 0;
        for (int i = 3; i >= 0; i--) begin
            dg = bcd[4*i +: 4];
            if (dg > 4'd9) r.bad = 1'b1;
            val = val * 10 + int'(dg);
        end
        r.bin = r.bad ? 16'h0 : val[15:0];
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_bin"}, 32'(binary_out), 32'(e.bin));
            check({tag, "_bad"}, 32'(bad_digit), 32'(e.bad));
        end
    endtask

    // Accept one word, scramble bcd_in afterwards, measure latency, compare, optionally ack.
    task automatic convert(input string tag, input logic [15:0] bcd, input bit ack);
        int lat;
        bit found;
        @(negedge clk);
        bcd_in    = bcd;
        in_valid  = 1'b1;
        out_ready = ack;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        sb.push_back(ref_model(bcd));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcd_in   = ~bcd;
        check({tag, "_busy"}, 32'({busy, in_ready}), 32'b10);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) found = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd14);
        compare_result(tag);
        if (ack) begin
            @(posedge clk);
            #1;
            check({tag, "_idle"}, 32'({out_valid, in_ready, busy}), 32'b010);
        end
    endtask

    logic [15:0] held_bin;
    logic        held_bad;
    int          t_out[2];
    bit          seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bcd_in    = 16'h0;
        #12;
        check("reset_outputs", 32'({in_ready, out_valid, bad_digit, busy}), 32'b1000);
        check("reset_bin", 32'(binary_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversions and boundary values.
        convert("t1_9999", 16'h9999, 1'b1);
        convert("t2_1234", 16'h1234, 1'b1);
        convert("t2_0000", 16'h0000, 1'b1);
        convert("t2_0001", 16'h0001, 1'b1);
        convert("t3_12A4", 16'h12A4, 1'b1);
        convert("t3_0042", 16'h0042, 1'b1);

        // Backpressure: result must hold and in_valid must be ignored.
        convert("t4_4321", 16'h4321, 1'b0);
        held_bin = binary_out;
        held_bad = bad_digit;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            bcd_in   = 16'h0777;
            check("t4_hold_bin", 32'(binary_out), 32'(held_bin));
            check("t4_hold_flags", 32'({out_valid, in_ready, busy, bad_digit}), 32'({3'b101, held_bad}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_release", 32'({out_valid, in_ready}), 32'b01);
        repeat (20) @(posedge clk);
        #1;
        check("t4_no_ghost", 32'({out_valid, in_ready}), 32'b01);

        // Asynchronous reset in the middle of step 7.
        @(negedge clk);
        bcd_in   = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_abort", 32'({out_valid, in_ready, busy, bad_digit}), 32'b0100);
        check("t5_abort_bin", 32'(binary_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_pulse", 32'(out_valid), 32'd0);
        convert("t5_0042", 16'h0042, 1'b1);

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        bcd_in    = 16'h0100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb.push_back(ref_model(16'h0100));
        sb.push_back(ref_model(16'h0255));
        @(posedge clk);
        #1;
        bcd_in = 16'h0255;
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("t6_seen", 32'(seen), 32'd1);
            t_out[k] = cyc;
            compare_result("t6_b2b");
        end
        in_valid = 1'b0;
        check("t6_spacing", 32'(t_out[1] - t_out[0]), 32'd16);
        @(posedge clk);
        #1;
        check("t6_idle", 32'({out_valid, in_ready}), 32'b01);

        // Strided sweep of the decimal range plus the top value.
        for (int v = 0; v < 10000; v += 37) begin
            convert("sweep", to_bcd(v), 1'b1);
        end
        convert("sweep_top", to_bcd(9999), 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
